// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: captures a multi-hot vector and emits the index
// of each set bit, highest first, one beat per output handshake.
module seq_priority_encoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       e,
  input  logic       in_valid,
  input  logic [7:0] in_bits,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_idx,
  output logic       out_last,
  output logic       out_none
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t     state_q, state_d;
  logic [7:0] pend_q, pend_d;
  logic       none_q, none_d;
  logic       one_left;

  // Ascending scan so the highest set bit wins; pending=0 encodes to 0.
  always_comb begin
    out_idx = '0;
    for (int i = 0; i < 8; i++)
      if (pend_q[i]) out_idx = 3'(i);
  end

  assign one_left  = (pend_q != '0) && ((pend_q & (pend_q - 8'd1)) == '0);
  assign out_valid = (state_q == EMIT);
  assign in_ready  = (state_q == IDLE) && e;
  assign out_none  = out_valid && none_q;
  assign out_last  = out_valid && (one_left || none_q);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    none_d  = none_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          pend_d  = in_bits;
          none_d  = (in_bits == '0);
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_d[out_idx] = 1'b0;
          if (out_last) begin
            pend_d  = '0;
            none_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      none_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      none_q  <= none_d;
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Directed bench: per-cycle vector table plus a throughput/ordering sequence.
module tb_seq_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n, e, in_valid, out_ready;
  logic [7:0] in_bits;
  logic       in_ready, out_valid, out_last, out_none;
  logic [2:0] out_idx;

  int errors = 0;
  int checks = 0;

  seq_priority_encoder dut (
    .clk(clk), .rst_n(rst_n), .e(e), .in_valid(in_valid), .in_bits(in_bits),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_none(out_none)
  );

  always #5 clk = ~clk;

  // One row: inputs held across an edge, expected outputs seen 1ns after it.
  typedef struct {
    logic       rst_n, e, iv;
    logic [7:0] bits;
    logic       ordy;
    logic       x_ir, x_ov;
    logic [2:0] x_idx;
    logic       x_last, x_none;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic en, input logic iv, input logic [7:0] b,
                     input logic o, input logic ir, input logic ov, input logic [2:0] idx,
                     input logic l, input logic n);
    vec_t v;
    v.rst_n = r; v.e = en; v.iv = iv; v.bits = b; v.ordy = o;
    v.x_ir = ir; v.x_ov = ov; v.x_idx = idx; v.x_last = l; v.x_none = n;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; e = 1'b1; in_valid = 1'b1; in_bits = 8'hA4; out_ready = 1'b1;

    //   rst e iv bits   ordy | ir ov idx last none
    // reset held 2 cycles with a vector offered
    add(0, 1, 1, 8'hA4, 1,   1, 0, 0, 0, 0);
    add(0, 1, 1, 8'hA4, 1,   1, 0, 0, 0, 0);
    add(1, 1, 0, 8'hA4, 1,   1, 0, 0, 0, 0);
    // 1010_0100 -> 7,5,2
    add(1, 1, 1, 8'hA4, 1,   0, 1, 7, 0, 0);
    add(1, 1, 0, 8'h00, 1,   0, 1, 5, 0, 0);
    add(1, 1, 0, 8'h00, 1,   0, 1, 2, 1, 0);
    add(1, 1, 0, 8'h00, 1,   1, 0, 0, 0, 0);
    // backpressure on 0000_0011
    add(1, 1, 1, 8'h03, 0,   0, 1, 1, 0, 0);
    add(1, 1, 0, 8'h00, 0,   0, 1, 1, 0, 0);
    add(1, 1, 0, 8'h00, 0,   0, 1, 1, 0, 0);
    add(1, 1, 0, 8'h00, 0,   0, 1, 1, 0, 0);
    add(1, 1, 0, 8'h00, 1,   0, 1, 0, 1, 0);
    add(1, 1, 0, 8'h00, 1,   1, 0, 0, 0, 0);
    // zero vector
    add(1, 1, 1, 8'h00, 1,   0, 1, 0, 1, 1);
    add(1, 1, 0, 8'h00, 1,   1, 0, 0, 0, 0);
    // enable gating
    add(1, 0, 1, 8'h80, 1,   0, 0, 0, 0, 0);
    add(1, 0, 1, 8'h80, 1,   0, 0, 0, 0, 0);
    add(1, 0, 1, 8'h80, 1,   0, 0, 0, 0, 0);
    add(1, 0, 1, 8'h80, 1,   0, 0, 0, 0, 0);
    add(1, 1, 1, 8'h80, 1,   0, 1, 7, 1, 0);
    add(1, 1, 0, 8'h80, 1,   1, 0, 0, 0, 0);
    // stale input after capture; e dropped mid-emission
    add(1, 1, 1, 8'h80, 0,   0, 1, 7, 1, 0);
    add(1, 0, 1, 8'h01, 0,   0, 1, 7, 1, 0);
    add(1, 0, 0, 8'h01, 1,   0, 0, 0, 0, 0);
    // reset mid-operation
    add(1, 1, 1, 8'hFF, 1,   0, 1, 7, 0, 0);
    add(1, 1, 0, 8'h00, 1,   0, 1, 6, 0, 0);
    add(1, 1, 0, 8'h00, 1,   0, 1, 5, 0, 0);
    add(0, 1, 1, 8'h33, 1,   1, 0, 0, 0, 0);
    add(1, 1, 0, 8'h00, 1,   1, 0, 0, 0, 0);
    add(1, 1, 1, 8'h10, 1,   0, 1, 4, 1, 0);
    add(1, 1, 0, 8'h00, 1,   1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n = tbl[i].rst_n; e = tbl[i].e; in_valid = tbl[i].iv;
      in_bits = tbl[i].bits; out_ready = tbl[i].ordy;
      tick();
      chk("in_ready",  i, {7'd0, in_ready},  {7'd0, tbl[i].x_ir});
      chk("out_valid", i, {7'd0, out_valid}, {7'd0, tbl[i].x_ov});
      chk("out_idx",   i, {5'd0, out_idx},   {5'd0, tbl[i].x_idx});
      chk("out_last",  i, {7'd0, out_last},  {7'd0, tbl[i].x_last});
      chk("out_none",  i, {7'd0, out_none},  {7'd0, tbl[i].x_none});
    end

    // Throughput: 8'hFF with out_ready=1 takes k+1 = 9 cycles, beats 7..0.
    e = 1'b1; in_valid = 1'b1; in_bits = 8'hFF; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; in_bits = 8'h00;
    cnt = 1;
    while (!in_ready && cnt < 40) begin
      chk("tp_valid", 100 + cnt, {7'd0, out_valid}, 8'd1);
      chk("tp_idx",   100 + cnt, {5'd0, out_idx},   8'(8 - cnt));
      chk("tp_last",  100 + cnt, {7'd0, out_last},  {7'd0, cnt == 8});
      tick();
      cnt++;
    end
    chk("tp_cycles", 200, 8'(cnt), 8'd9);
    chk("tp_idle_valid", 201, {7'd0, out_valid}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_priority_encoder.md
SEQ_PRIORITY_ENCODER -- requirements
Module: seq_priority_encoder

Interface
REQ-001 The block SHALL have one clock; reset SHALL be synchronous and active-low.
REQ-002 Port `clk`  in  1  rising-edge clock for all state.
REQ-003 Port `rst_n`  in  1  synchronous active-low reset, sampled on `clk` rise.
REQ-004 Port `e`  in  1  enable; gates acceptance of new vectors only.
REQ-005 Port `in_valid`  in  1  upstream presents a request vector.
REQ-006 Port `in_bits`  in  8  multi-hot request vector; bit i requests index i.
REQ-007 Port `in_ready`  out  1  block can accept a vector this cycle.
REQ-008 Port `out_valid`  out  1  `out_idx`, `out_last` and `out_none` are valid.
REQ-009 Port `out_ready`  in  1  downstream accepts the current beat.
REQ-010 Port `out_idx`  out  3  encoded index of the current set bit.
REQ-011 Port `out_last`  out  1  current beat is the final beat of the vector.
REQ-012 Port `out_none`  out  1  the accepted vector was all-zero.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and EMIT.
REQ-014 `in_ready` SHALL equal (state==IDLE) && `e`, driven combinationally from registered state.
REQ-015 Input handshake: `in_valid` && `in_ready` at a rising edge SHALL capture `in_bits` into an 8-bit pending register and move IDLE->EMIT.
REQ-016 Latency: `out_valid` SHALL rise on the cycle after the input handshake. There SHALL be no same-cycle bypass.
REQ-017 In EMIT, `out_idx` SHALL be the highest set bit of the pending register, so beats are emitted in descending index order.
REQ-018 Output handshake: `out_valid` && `out_ready` at a rising edge SHALL clear the pending bit named by `out_idx`.
REQ-019 `out_last` SHALL be 1 when exactly one bit remains pending, or when `out_none`=1.
REQ-020 A handshake on a beat with `out_last`=1 SHALL return the FSM to IDLE. `out_valid` SHALL be 0 and `in_ready` SHALL equal `e` on the next cycle.
REQ-021 Throughput: with `out_ready` held at 1, the block SHALL emit one beat per cycle. A vector with k set bits SHALL occupy k+1 cycles from input handshake to the next `in_ready`.
REQ-022 Zero vector: accepting `in_bits`=0 SHALL produce exactly one beat with `out_idx`=0, `out_none`=1 and `out_last`=1.
REQ-023 While `out_valid`=1 and `out_ready`=0, `out_idx`, `out_last` and `out_none` SHALL hold stable, and `out_valid` SHALL stay 1.
REQ-024 `out_valid` SHALL be 1 exactly when state==EMIT.
REQ-025 The block SHALL never accept a new vector while in EMIT; `in_ready`=0 throughout EMIT.
REQ-026 `e`=0 SHALL block new acceptance only. Emission in progress SHALL continue unaffected.
REQ-027 Changes to `in_bits` after capture SHALL have no effect on the beats being emitted.

Reset
REQ-028 When `rst_n`=0 at a rising edge, the block SHALL set:
- state = IDLE;
- pending = 0;
- `out_valid` = 0, `out_idx` = 0, `out_last` = 0, `out_none` = 0.
REQ-029 Reset SHALL take priority over any simultaneous handshake.
REQ-030 Reset asserted during EMIT SHALL discard all remaining pending bits; no further beats SHALL be emitted for that vector.
REQ-031 After reset deasserts, `in_ready` SHALL equal `e` on the first cycle.

Verification
REQ-032 Reset scenario: hold `rst_n`=0 for 2 cycles with `in_valid`=1 and `e`=1, then release -> `out_valid`=0 and `out_idx`=0 during reset; `in_ready`=1 on the first cycle after release; no vector accepted during reset.
REQ-033 Multi-bit vector: `in_bits`=8'b1010_0100, `e`=1, `out_ready`=1 -> beats `out_idx`=7,5,2 on three consecutive cycles starting 1 cycle after the handshake; `out_last`=1 only on idx 2; `in_ready`=1 on the following cycle.
REQ-034 Backpressure: `in_bits`=8'b0000_0011 with `out_ready`=0 for 3 cycles, then 1 -> idx 1 held stable for 3 cycles, then idx 1 and idx 0 transfer on consecutive cycles; `out_last`=1 on idx 0.
REQ-035 Zero vector: `in_bits`=8'h00 accepted -> exactly one beat with `out_idx`=0, `out_none`=1, `out_last`=1; no further beats.
REQ-036 Enable gating and stale input: offer `in_bits`=8'h80 with `e`=0 for 4 cycles -> `in_ready`=0 and no beats. Raise `e` -> accepted, then single beat idx 7 with `out_last`=1. In a separate run, change `in_bits` to 8'h01 after capture -> beat is still idx 7.
REQ-037 Reset mid-operation: accept 8'hFF, transfer idx 7 and idx 6, then pulse `rst_n`=0 -> `out_valid`=0 next cycle; no further beats; next vector 8'h10 yields a single beat idx 4.
